// File: rtl/vc_control_fsm_if.sv
// Purpose : bundle of link, buffer, allocator and crossbar signals that
//           connect one router input port controller to its environment.
// Ports   : valid_in/vc_in/ready_in         upstream link
//           push_buffer/popBuffer/full/empty/head_type  per-VC flit buffers
//           reserveRoute/routeReserveStatus/routeRelieve  switch allocator
//           valid_out/vc_out/ready_out/phitCounter        crossbar output
//           proto_err                        sticky per-VC protocol error
// Modports: master = input port controller, slave = surrounding logic.
interface vc_control_fsm_if #(
    parameter int VC_COUNT    = 4,
    parameter int VC_WIDTH    = $clog2(VC_COUNT),
    parameter int PhitPerFlit = 1,
    parameter int TYPE_WIDTH  = 2,
    parameter int PHIT_WIDTH  = $clog2(PhitPerFlit) + 1
);
    logic                           valid_in;
    logic [VC_WIDTH-1:0]            vc_in;
    logic [VC_COUNT-1:0]            ready_in;
    logic [VC_COUNT-1:0]            push_buffer;
    logic [VC_COUNT-1:0]            full;
    logic [VC_COUNT-1:0]            empty;
    logic [VC_COUNT*TYPE_WIDTH-1:0] head_type;
    logic [VC_COUNT-1:0]            reserveRoute;
    logic [VC_COUNT-1:0]            routeReserveStatus;
    logic [VC_COUNT-1:0]            routeRelieve;
    logic                           valid_out;
    logic [VC_WIDTH-1:0]            vc_out;
    logic                           ready_out;
    logic [VC_COUNT-1:0]            popBuffer;
    logic [PHIT_WIDTH-1:0]          phitCounter;
    logic [VC_COUNT-1:0]            proto_err;

    modport master (
        input  valid_in, vc_in, full, empty, head_type, routeReserveStatus, ready_out,
        output ready_in, push_buffer, reserveRoute, routeRelieve,
               valid_out, vc_out, popBuffer, phitCounter, proto_err
    );

    modport slave (
        output valid_in, vc_in, full, empty, head_type, routeReserveStatus, ready_out,
        input  ready_in, push_buffer, reserveRoute, routeRelieve,
               valid_out, vc_out, popBuffer, phitCounter, proto_err
    );
endinterface

// File: rtl/vc_control_fsm.sv
// Purpose : multi-VC input port controller. Per-VC push/pop, one route
//           reservation FSM per VC, and a round-robin, flit-atomic,
//           multi-phit arbiter onto the crossbar output.
// Ports   : clk  - clock, rising edge
//           rst  - asynchronous active-low reset
//           bus  - vc_control_fsm_if.master (link, buffers, allocator, output)
//
// Per-VC state table
//   state      | meaning
//   ST_IDLE    | no route held; waits for a head/single flit at buffer head
//   ST_REQ     | reserveRoute high until the allocator grant pulse
//   ST_ACTIVE  | route held; VC competes for the output while non-empty
//   ST_RELIEVE | routeRelieve high for one cycle, then back to IDLE
module vc_control_fsm #(
    parameter int VC_COUNT    = 4,
    parameter int VC_WIDTH    = $clog2(VC_COUNT),
    parameter int PhitPerFlit = 1,
    parameter int TYPE_WIDTH  = 2
) (
    input logic              clk,
    input logic              rst,
    vc_control_fsm_if.master bus
);
    localparam int PHIT_WIDTH = $clog2(PhitPerFlit) + 1;
    localparam logic [PHIT_WIDTH-1:0] LAST_PHIT = PHIT_WIDTH'(PhitPerFlit - 1);
    localparam logic [TYPE_WIDTH-1:0] T_SINGLE = TYPE_WIDTH'(0);
    localparam logic [TYPE_WIDTH-1:0] T_HEAD   = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] T_TAIL   = TYPE_WIDTH'(3);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELIEVE = 2'd3
    } vc_state_t;

    vc_state_t r_state [VC_COUNT];
    vc_state_t w_state_nxt [VC_COUNT];

    // r_run rises on the first clock edge after reset release, so that
    // leaving reset is seen synchronously by all of the control logic.
    logic                  r_run;
    logic [VC_WIDTH-1:0]   r_rr;
    logic                  r_lock;
    logic [VC_WIDTH-1:0]   r_lock_vc;
    logic [PHIT_WIDTH-1:0] r_phit;
    logic [VC_COUNT-1:0]   r_proto_err;

    logic [TYPE_WIDTH-1:0] w_type [VC_COUNT];
    logic [VC_COUNT-1:0]   w_is_start;
    logic [VC_COUNT-1:0]   w_is_end;
    logic [VC_COUNT-1:0]   w_eligible;
    logic [VC_COUNT-1:0]   w_drop;
    logic                  w_arb_valid;
    logic [VC_WIDTH-1:0]   w_arb_vc;
    logic                  w_grant_valid;
    logic [VC_WIDTH-1:0]   w_grant_vc;
    logic                  w_hs;
    logic                  w_last;

    always_comb begin
        for (int v = 0; v < VC_COUNT; v++) begin
            w_type[v]     = bus.head_type[v*TYPE_WIDTH +: TYPE_WIDTH];
            w_is_start[v] = (w_type[v] == T_SINGLE) || (w_type[v] == T_HEAD);
            w_is_end[v]   = (w_type[v] == T_SINGLE) || (w_type[v] == T_TAIL);
            // A body/tail flit reaching an idle VC has no route: drop it.
            w_drop[v]     = r_run && (r_state[v] == ST_IDLE) && !bus.empty[v] && !w_is_start[v];
            w_eligible[v] = r_run && (r_state[v] == ST_ACTIVE) && !bus.empty[v];
        end
    end

    // Round-robin scan: first eligible VC at or after r_rr, wrapping.
    always_comb begin
        logic [VC_WIDTH-1:0] idx;
        idx         = '0;
        w_arb_valid = 1'b0;
        w_arb_vc    = '0;
        for (int i = 0; i < VC_COUNT; i++) begin
            idx = VC_WIDTH'((int'(r_rr) + i) % VC_COUNT);
            if (!w_arb_valid && w_eligible[idx]) begin
                w_arb_valid = 1'b1;
                w_arb_vc    = idx;
            end
        end
    end

    // Once the first phit has gone, the grant stays on that VC until the
    // last phit completes, regardless of ready_out or other requesters.
    assign w_grant_valid = r_lock || w_arb_valid;
    assign w_grant_vc    = r_lock ? r_lock_vc : w_arb_vc;
    assign w_hs          = w_grant_valid && bus.ready_out;
    assign w_last        = w_hs && (r_phit == LAST_PHIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VC_COUNT; v++) begin
                r_state[v] <= ST_IDLE;
            end
        end else begin
            for (int v = 0; v < VC_COUNT; v++) begin
                r_state[v] <= w_state_nxt[v];
            end
        end
    end

    always_comb begin
        for (int v = 0; v < VC_COUNT; v++) begin
            w_state_nxt[v] = r_state[v];
            case (r_state[v])
                ST_IDLE: begin
                    if (r_run && !bus.empty[v] && w_is_start[v]) begin
                        w_state_nxt[v] = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.routeReserveStatus[v]) begin
                        w_state_nxt[v] = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_last && (w_grant_vc == VC_WIDTH'(v)) && w_is_end[v]) begin
                        w_state_nxt[v] = ST_RELIEVE;
                    end
                end
                ST_RELIEVE: w_state_nxt[v] = ST_IDLE;
                default:    w_state_nxt[v] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ready_in     = r_run ? ~bus.full : '0;
        bus.push_buffer  = '0;
        bus.reserveRoute = '0;
        bus.routeRelieve = '0;
        bus.popBuffer    = '0;
        for (int v = 0; v < VC_COUNT; v++) begin
            bus.push_buffer[v]  = r_run && bus.valid_in && (bus.vc_in == VC_WIDTH'(v)) && !bus.full[v];
            bus.reserveRoute[v] = (r_state[v] == ST_REQ);
            bus.routeRelieve[v] = (r_state[v] == ST_RELIEVE);
            bus.popBuffer[v]    = w_drop[v] || (w_last && (w_grant_vc == VC_WIDTH'(v)));
        end
        bus.valid_out   = w_grant_valid;
        bus.vc_out      = w_grant_valid ? w_grant_vc : '0;
        bus.phitCounter = r_phit;
        bus.proto_err   = r_proto_err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run       <= 1'b0;
            r_rr        <= '0;
            r_lock      <= 1'b0;
            r_lock_vc   <= '0;
            r_phit      <= '0;
            r_proto_err <= '0;
        end else begin
            r_run       <= 1'b1;
            r_proto_err <= r_proto_err | w_drop;
            if (w_last) begin
                r_phit <= '0;
                r_lock <= 1'b0;
                r_rr   <= (w_grant_vc == VC_WIDTH'(VC_COUNT - 1)) ? '0 : w_grant_vc + 1'b1;
            end else if (w_hs) begin
                r_phit    <= r_phit + 1'b1;
                r_lock    <= 1'b1;
                r_lock_vc <= w_grant_vc;
            end
        end
    end
endmodule

// File: tb/tb_vc_control_fsm.sv
// Purpose : directed bench for vc_control_fsm. Two instances: u_dut1 with
//           one phit per flit and u_dut4 with four. A small FIFO model per
//           VC stands in for the flit buffers; popped flits of u_dut1 are
//           compared against a queue of expected VCs.
module tb_vc_control_fsm;
    localparam int NV    = 4;
    localparam int TW    = 2;
    localparam int DEPTH = 8;
    localparam logic [1:0] T_SINGLE = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_BODY   = 2'b10;
    localparam logic [1:0] T_TAIL   = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vc_control_fsm_if #(.VC_COUNT(NV), .PhitPerFlit(1)) if1 ();
    vc_control_fsm_if #(.VC_COUNT(NV), .PhitPerFlit(4)) if4 ();

    vc_control_fsm #(.VC_COUNT(NV), .PhitPerFlit(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    vc_control_fsm #(.VC_COUNT(NV), .PhitPerFlit(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flit buffer model, index 0 = u_dut1, 1 = u_dut4.
    logic [1:0]        mem [2][NV][DEPTH];
    logic [2:0]        rd  [2][NV] = '{default: 3'd0};
    logic [2:0]        wr  [2][NV] = '{default: 3'd0};
    int                cnt [2][NV] = '{default: 0};
    logic [1:0]        ityp [2];
    logic [NV-1:0]     force_full [2];
    logic [NV-1:0]     pb [2];
    logic [NV-1:0]     pop [2];
    logic [NV-1:0]     full_w [2];
    logic [NV-1:0]     empty_w [2];
    logic [NV*TW-1:0]  ht_w [2];

    assign pb[0]  = if1.push_buffer;
    assign pb[1]  = if4.push_buffer;
    assign pop[0] = if1.popBuffer;
    assign pop[1] = if4.popBuffer;
    assign if1.full      = full_w[0];
    assign if4.full      = full_w[1];
    assign if1.empty     = empty_w[0];
    assign if4.empty     = empty_w[1];
    assign if1.head_type = ht_w[0];
    assign if4.head_type = ht_w[1];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int v = 0; v < NV; v++) begin
                if (pb[i][v]) begin
                    mem[i][v][wr[i][v]] <= ityp[i];
                    wr[i][v] <= wr[i][v] + 3'd1;
                end
                if (pop[i][v]) rd[i][v] <= rd[i][v] + 3'd1;
                cnt[i][v] <= cnt[i][v] + (pb[i][v] ? 1 : 0) - (pop[i][v] ? 1 : 0);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            full_w[i]  = '0;
            empty_w[i] = '0;
            ht_w[i]    = '0;
            for (int v = 0; v < NV; v++) begin
                full_w[i][v]        = force_full[i][v] | (cnt[i][v] == DEPTH);
                empty_w[i][v]       = (cnt[i][v] == 0);
                ht_w[i][v*TW +: TW] = mem[i][v][rd[i][v]];
            end
        end
    end

    // Scoreboard for u_dut1: every output handshake pops the expected VC.
    int exp1 [$];
    int sb_e;
    always @(negedge clk) begin
        if (rst && if1.valid_out && if1.ready_out) begin
            if (exp1.size() == 0) begin
                check("sb_unexpected_flit", 32'(if1.vc_out), 32'hFFFF_FFFF);
            end else begin
                sb_e = exp1.pop_front();
                check("sb_vc_out", 32'(if1.vc_out), 32'(sb_e));
                check("sb_popBuffer", 32'(if1.popBuffer), 32'(1 << sb_e));
            end
        end
    end

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [1:0] t1_types [6] = '{T_HEAD, T_BODY, T_BODY, T_BODY, T_BODY, T_TAIL};
    logic [1:0] t2_types [3] = '{T_HEAD, T_BODY, T_TAIL};
    logic       t3_ready [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int         pc_exp;

    initial begin
        ityp[0] = T_SINGLE; ityp[1] = T_SINGLE;
        force_full[0] = '0; force_full[1] = '0;
        if1.valid_in = 1'b0; if1.vc_in = '0; if1.routeReserveStatus = '0; if1.ready_out = 1'b0;
        if4.valid_in = 1'b0; if4.vc_in = '0; if4.routeReserveStatus = '0; if4.ready_out = 1'b0;

        // Reset state
        mid();
        check("rst_valid_out", 32'(if1.valid_out), 32'd0);
        check("rst_phit4", 32'(if4.phitCounter), 32'd0);
        check("rst_reserve", 32'(if1.reserveRoute), 32'd0);
        check("rst_proto_err", 32'(if1.proto_err), 32'd0);
        #2 rst = 1'b1;
        nc();

        // Packet head + 4 body + tail on VC0 of u_dut1, grant in 4th REQ cycle
        if1.ready_out = 1'b1;
        if1.valid_in  = 1'b1;
        if1.vc_in     = 2'd0;
        for (int k = 0; k < 6; k++) begin
            ityp[0] = t1_types[k];
            if1.routeReserveStatus = (k == 5) ? 4'b0001 : 4'b0000;
            exp1.push_back(0);
            #1 check("t1_push_buffer", 32'(if1.push_buffer), 32'b0001);
            nc();
            check("t1_reserveRoute", 32'(if1.reserveRoute), (k >= 1 && k <= 4) ? 32'b0001 : 32'd0);
        end
        if1.valid_in = 1'b0;
        if1.routeReserveStatus = '0;
        for (int k = 0; k < 6; k++) begin
            mid();
            check("t1_pop_each_cycle", 32'(if1.popBuffer), 32'b0001);
            check("t1_no_relieve_yet", 32'(if1.routeRelieve), 32'd0);
            nc();
        end
        mid();
        check("t1_relieve", 32'(if1.routeRelieve), 32'b0001);
        check("t1_valid_after", 32'(if1.valid_out), 32'd0);
        nc();
        mid();
        check("t1_relieve_one_cycle", 32'(if1.routeRelieve), 32'd0);
        check("t1_reserve_low", 32'(if1.reserveRoute), 32'd0);

        // VC1 and VC3 active with three flits each: round-robin interleave
        nc();
        if1.ready_out = 1'b0;
        if1.valid_in  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if1.vc_in = (k < 3) ? 2'd1 : 2'd3;
            ityp[0]   = t2_types[k % 3];
            nc();
        end
        if1.valid_in = 1'b0;
        if1.routeReserveStatus = 4'b1010;
        mid();
        check("t2_reserve_both", 32'(if1.reserveRoute), 32'b1010);
        nc();
        if1.routeReserveStatus = '0;
        mid();
        check("t2_valid_waiting", 32'(if1.valid_out), 32'd1);
        check("t2_first_vc", 32'(if1.vc_out), 32'd1);
        check("t2_no_pop_unready", 32'(if1.popBuffer), 32'd0);
        nc();
        for (int k = 0; k < 6; k++) exp1.push_back((k % 2 == 0) ? 1 : 3);
        if1.ready_out = 1'b1;
        for (int k = 0; k < 6; k++) begin
            nc();
            if (k == 4) check("t2_relieve_vc1", 32'(if1.routeRelieve), 32'b0010);
        end
        if1.ready_out = 1'b0;
        mid();
        check("t2_relieve_vc3", 32'(if1.routeRelieve), 32'b1000);
        check("t2_valid_done", 32'(if1.valid_out), 32'd0);

        // Full VC blocks the push; releasing full accepts in the same cycle
        nc();
        force_full[0] = 4'b0010;
        if1.valid_in  = 1'b1;
        if1.vc_in     = 2'd1;
        ityp[0]       = T_HEAD;
        #1;
        check("t4_push_blocked", 32'(if1.push_buffer), 32'd0);
        check("t4_ready_in_full", 32'(if1.ready_in), 32'b1101);
        force_full[0] = 4'b0000;
        #1;
        check("t4_push_released", 32'(if1.push_buffer), 32'b0010);
        check("t4_ready_in", 32'(if1.ready_in), 32'b1111);
        nc();

        // Body flit at the head of idle VC0: dropped, sticky proto_err
        if1.vc_in = 2'd0;
        ityp[0]   = T_BODY;
        nc();
        if1.valid_in = 1'b0;
        mid();
        check("t5_drop_pop", 32'(if1.popBuffer), 32'b0001);
        check("t5_no_reserve", 32'(if1.reserveRoute), 32'b0010);
        nc();
        mid();
        check("t5_pop_once", 32'(if1.popBuffer), 32'd0);
        check("t5_proto_err", 32'(if1.proto_err), 32'b0001);
        check("t5_no_reserve_after", 32'(if1.reserveRoute), 32'b0010);
        repeat (3) nc();
        check("t5_proto_sticky", 32'(if1.proto_err), 32'b0001);

        // Four phits, single flit on VC2 of u_dut4, ready_out toggling
        if4.valid_in = 1'b1;
        if4.vc_in    = 2'd2;
        ityp[1]      = T_SINGLE;
        nc();
        if4.valid_in = 1'b0;
        nc();
        if4.routeReserveStatus = 4'b0100;
        mid();
        check("t3_reserve", 32'(if4.reserveRoute), 32'b0100);
        nc();
        if4.routeReserveStatus = '0;
        mid();
        check("t3_valid", 32'(if4.valid_out), 32'd1);
        check("t3_vc_out_start", 32'(if4.vc_out), 32'd2);
        pc_exp = 0;
        for (int k = 0; k < 6; k++) begin
            nc();
            if4.ready_out = t3_ready[k];
            mid();
            check("t3_phitCounter", 32'(if4.phitCounter), 32'(pc_exp));
            check("t3_vc_out_locked", 32'(if4.vc_out), 32'd2);
            check("t3_valid_locked", 32'(if4.valid_out), 32'd1);
            check("t3_popBuffer", 32'(if4.popBuffer), (t3_ready[k] && pc_exp == 3) ? 32'b0100 : 32'd0);
            if (t3_ready[k]) pc_exp = (pc_exp == 3) ? 0 : pc_exp + 1;
        end
        nc();
        if4.ready_out = 1'b0;
        mid();
        check("t3_phit_wrapped", 32'(if4.phitCounter), 32'd0);
        check("t3_relieve", 32'(if4.routeRelieve), 32'b0100);

        // Asynchronous reset mid-flit on VC0 of u_dut4 at phitCounter 2
        nc();
        if4.valid_in = 1'b1;
        if4.vc_in    = 2'd0;
        ityp[1]      = T_SINGLE;
        nc();
        if4.valid_in = 1'b0;
        nc();
        if4.routeReserveStatus = 4'b0001;
        nc();
        if4.routeReserveStatus = '0;
        if4.ready_out = 1'b1;
        nc();
        nc();
        if4.ready_out = 1'b0;
        mid();
        check("t6_phit_before", 32'(if4.phitCounter), 32'd2);
        check("t6_vc_before", 32'(if4.vc_out), 32'd0);
        #2;
        rst = 1'b0;
        if4.ready_out = 1'b1;
        #1;
        check("t6_rst_valid", 32'(if4.valid_out), 32'd0);
        check("t6_rst_phit", 32'(if4.phitCounter), 32'd0);
        check("t6_rst_pop", 32'(if4.popBuffer), 32'd0);
        check("t6_rst_reserve", 32'(if4.reserveRoute), 32'd0);
        check("t6_rst_relieve", 32'(if4.routeRelieve), 32'd0);
        check("t6_rst_vc_out", 32'(if4.vc_out), 32'd0);
        check("t6_rst_proto_err", 32'(if1.proto_err), 32'd0);
        check("t6_rst_reserve1", 32'(if1.reserveRoute), 32'd0);
        nc();
        check("t6_rst_hold_valid", 32'(if4.valid_out), 32'd0);
        check("t6_flit_kept", 32'(cnt[1][0]), 32'd1);
        if4.ready_out = 1'b0;
        mid();
        #2 rst = 1'b1;
        nc();
        check("t6_release_sync", 32'(if4.reserveRoute), 32'd0);
        nc();
        check("t6_rerequest", 32'(if4.reserveRoute), 32'b0001);
        check("t6_rerequest_dut1", 32'(if1.reserveRoute), 32'b0010);

        check("sb_all_consumed", 32'(exp1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
